vram_dp_ctrl: RTL and testbench
===============================

Name: vram_dp_ctrl

Overview:
- Parametrised true-dual-port video RAM for the GBA VRAM banks. Successor to the fixed 16K x 32 asynchronous-read VRAM.
- Adds byte-lane write strobes, registered reads with a valid strobe, defined same-address collision behaviour, and a hardware clear sequencer that zeroes the array after reset.
- Port A serves the CPU/DMA bus; port B serves the PPU fetch path.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 14, word address width.
- DEPTH, 16384, number of words; must be <= 2**ADDR_W.
- RDW_MODE, 0, cross-port read-during-write result: 0 = write-first (new data), 1 = read-first (old data).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear.

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous, active-low reset
- a_en  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_be  in  DATA_W/8  port A byte-lane write enables
- a_addr  in  ADDR_W  port A word address
- a_din  in  DATA_W  port A write data
- a_dout  out  DATA_W  port A read data
- a_rvalid  out  1  port A read data valid, one-cycle pulse
- b_en, b_we, b_be, b_addr, b_din, b_dout, b_rvalid: same as the port A set, for port B
- ready  out  1  array accepting accesses
- busy  out  1  clear sequence in progress
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - a_dout = b_dout = 0; a_rvalid = b_rvalid = 0; collision = 0.
  - CLEAR_ON_RESET = 1: busy = 1, ready = 0, clear counter = 0.
  - CLEAR_ON_RESET = 0: busy = 0, ready = 0.
- State machine RST -> CLEAR -> RUN:
  - RST is held while rst_n = 0.
  - First rising edge after deassertion: go to CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR writes 0 to word[cnt] each cycle, cnt = 0..DEPTH-1.
  - After the write to DEPTH-1: next state RUN, busy = 0, ready = 1. The clear takes exactly DEPTH cycles.
  - Asserting rst_n mid-clear aborts immediately; the clear restarts from word 0 after release.
- Requests while ready = 0 are ignored: no write, no rvalid.
- Reads (x_en = 1, x_we = 0, ready = 1):
  - x_dout is registered; valid on the cycle after the request.
  - x_rvalid pulses high for that one cycle.
  - x_dout holds its last value when no read completes.
  - Back-to-back reads give one result per cycle.
- Writes (x_en = 1, x_we = 1, ready = 1):
  - Byte lane i of the word is updated iff x_be[i] = 1.
  - x_be = 0 makes the write a no-op.
  - Writes never assert rvalid.
- Same-address write/write, both ports in the same cycle:
  - Lanes enabled on A take A data; lanes enabled only on B take B data.
  - collision pulses on the next cycle, only if at least one byte lane overlaps.
- Cross-port read-during-write (one port reads the address the other writes that cycle):
  - RDW_MODE = 0: the read returns the merged new word.
  - RDW_MODE = 1: the read returns the pre-write word.
- Address range:
  - Addresses >= DEPTH: writes are dropped, reads return 0 with rvalid still pulsed.
  - The clear counter never exceeds DEPTH-1.
- Inferable as block RAM; read latency is fixed at 1 with no bypass stage beyond the RDW mux.

Test Plan:
- Clear: DEPTH = 16, CLEAR_ON_RESET = 1.
  - Pre-load garbage via backdoor, pulse rst_n low -> busy = 1 for exactly 16 cycles, then ready = 1.
  - A reads of addr 0..15 all return 0x00000000 with rvalid one cycle after each request.
- Byte lanes:
  - A writes 0xAABBCCDD to addr 5, be = 0xF; then A writes 0x11223344, be = 0b0101.
  - B read of addr 5 -> 0xAA22CC44, b_rvalid high exactly one cycle after the request.
- Write/write collision: same cycle, A writes 0x11111111 be = 0b0011, B writes 0x22222222 be = 0b0110, addr 7.
  - Word = 0x00221111; collision = 1 for one cycle.
  - Repeat with B be = 0b1100 -> word = 0x22221111, collision stays 0.
- Read-during-write: word 3 = 0xDEADBEEF; A writes 0xCAFEF00D to addr 3 while B reads addr 3.
  - RDW_MODE = 0 -> b_dout = 0xCAFEF00D.
  - RDW_MODE = 1 -> b_dout = 0xDEADBEEF.
- Reset mid-clear: DEPTH = 16, assert rst_n at clear cycle 9.
  - Outputs return to reset values asynchronously.
  - After release, busy = 1 for a full 16 cycles again; requests during busy cause no write and no rvalid.
- Out of range: DEPTH = 12, ADDR_W = 4; A writes 0xFFFFFFFF to addr 13, then reads addr 13.
  - a_dout = 0, a_rvalid = 1.
  - Words 0..11 unchanged.

Source files
------------

// File: rtl/vram_dp_ctrl_if.sv
// rtl/vram_dp_ctrl_if.sv - one VRAM access port (request, write data, registered read data)
interface vram_dp_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    logic                  en;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic                  rvalid;

    modport master (output en, we, be, addr, din, input dout, rvalid);
    modport slave  (input en, we, be, addr, din, output dout, rvalid);
endinterface

// File: rtl/vram_dp_ctrl.sv
// rtl/vram_dp_ctrl.sv - true dual-port VRAM with byte lanes, registered reads and post-reset clear
module vram_dp_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    vram_dp_ctrl_if.slave  a,
    vram_dp_ctrl_if.slave  b,
    output logic           ready,
    output logic           busy,
    output logic           collision
);
    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_in, b_in, a_wr, b_wr, a_rd, b_rd, same_addr;
    logic [DATA_W-1:0]   a_old, b_old, a_rdata, b_rdata;

    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] base,
                                                     input logic [DATA_W-1:0] din,
                                                     input logic [NB-1:0]     be);
        lane_merge = base;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) lane_merge[8*i +: 8] = din[8*i +: 8];
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (cnt == LAST) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_RST;
        endcase
    end

    always_comb begin
        ready = (state == ST_RUN);
        busy  = (state == ST_CLEAR) || ((state == ST_RST) && (CLEAR_ON_RESET != 0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt <= '0;
        else if (state != ST_CLEAR)                cnt <= '0;
        else if (cnt != LAST)                      cnt <= cnt + 1'b1;
    end

    // Out-of-range addresses never touch the array; reads of them return zero.
    always_comb begin
        a_in      = ({1'b0, a.addr} < DEPTH_L);
        b_in      = ({1'b0, b.addr} < DEPTH_L);
        a_wr      = ready && a.en && a.we && a_in;
        b_wr      = ready && b.en && b.we && b_in;
        a_rd      = ready && a.en && !a.we;
        b_rd      = ready && b.en && !b.we;
        same_addr = (a.addr == b.addr);
        a_old     = a_in ? mem[a.addr] : '0;
        b_old     = b_in ? mem[b.addr] : '0;
        a_rdata   = a_old;
        b_rdata   = b_old;
        if (RDW_MODE == 0 && b_wr && same_addr) a_rdata = lane_merge(a_old, b.din, b.be);
        if (RDW_MODE == 0 && a_wr && same_addr) b_rdata = lane_merge(b_old, a.din, a.be);
    end

    // Port A lanes are written last so they win over port B on a shared address.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b.be[i]) mem[b.addr][8*i +: 8] <= b.din[8*i +: 8];
                if (a_wr && a.be[i]) mem[a.addr][8*i +: 8] <= a.din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a.dout    <= '0;
            b.dout    <= '0;
            a.rvalid  <= 1'b0;
            b.rvalid  <= 1'b0;
            collision <= 1'b0;
        end else begin
            a.rvalid  <= a_rd;
            b.rvalid  <= b_rd;
            if (a_rd) a.dout <= a_rdata;
            if (b_rd) b.dout <= b_rdata;
            collision <= a_wr && b_wr && same_addr && ((a.be & b.be) != '0);
        end
    end
endmodule

// File: tb/tb_vram_dp_ctrl.sv
// tb/tb_vram_dp_ctrl.sv - scoreboard bench for vram_dp_ctrl, write-first and read-first instances
module tb_vram_dp_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_be, b_be, a_addr, b_addr;
    logic [31:0] a_din, b_din;

    vram_dp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ia0 ();
    vram_dp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ib0 ();
    vram_dp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ia1 ();
    vram_dp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ib1 ();

    assign ia0.en = a_en;  assign ia0.we = a_we;  assign ia0.be = a_be;
    assign ia0.addr = a_addr;  assign ia0.din = a_din;
    assign ia1.en = a_en;  assign ia1.we = a_we;  assign ia1.be = a_be;
    assign ia1.addr = a_addr;  assign ia1.din = a_din;
    assign ib0.en = b_en;  assign ib0.we = b_we;  assign ib0.be = b_be;
    assign ib0.addr = b_addr;  assign ib0.din = b_din;
    assign ib1.en = b_en;  assign ib1.we = b_we;  assign ib1.be = b_be;
    assign ib1.addr = b_addr;  assign ib1.din = b_din;

    logic ready0, busy0, coll0, ready1, busy1, coll1;

    vram_dp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(ia0), .b(ib0),
        .ready(ready0), .busy(busy0), .collision(coll0));

    vram_dp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(ia1), .b(ib1),
        .ready(ready1), .busy(busy1), .collision(coll1));

    logic [31:0] dout_w [4];
    logic        rv_w   [4];
    logic        rdy_w  [2];
    logic        busy_w [2];
    logic        coll_w [2];
    assign dout_w[0] = ia0.dout;  assign rv_w[0] = ia0.rvalid;
    assign dout_w[1] = ib0.dout;  assign rv_w[1] = ib0.rvalid;
    assign dout_w[2] = ia1.dout;  assign rv_w[2] = ia1.rvalid;
    assign dout_w[3] = ib1.dout;  assign rv_w[3] = ib1.rvalid;
    assign rdy_w[0] = ready0;  assign busy_w[0] = busy0;  assign coll_w[0] = coll0;
    assign rdy_w[1] = ready1;  assign busy_w[1] = busy1;  assign coll_w[1] = coll1;

    // Reference model: instance 0 is 16 words write-first, instance 1 is 12 words read-first.
    logic [31:0] m [2][16];
    exp_t        q [4][$];
    logic [31:0] last [4];
    logic        exp_coll [2];
    exp_t        mon_e;
    int          cyc;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic int dep(input int d);
        return (d == 1) ? 12 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_din = 0;
        b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_din = 0;
    endtask

    task automatic set_a(input logic we, input logic [3:0] be, input logic [3:0] addr, input logic [31:0] din);
        a_en = 1; a_we = we; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic we, input logic [3:0] be, input logic [3:0] addr, input logic [31:0] din);
        b_en = 1; b_we = we; b_be = be; b_addr = addr; b_din = din;
    endtask

    // A read observes the word as it stands after this cycle's writes (write-first)
    // or before them (read-first); port A lanes override port B lanes.
    task automatic model_step(input int d);
        logic [31:0] nw [16];
        bit          wa, wb;
        int          dp;
        exp_t        e;
        dp = dep(d);
        nw = m[d];
        wa = a_en && a_we && (int'(a_addr) < dp);
        wb = b_en && b_we && (int'(b_addr) < dp);
        for (int i = 0; i < 4; i++) begin
            if (wb && b_be[i]) nw[b_addr][8*i +: 8] = b_din[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            if (wa && a_be[i]) nw[a_addr][8*i +: 8] = a_din[8*i +: 8];
        end
        e.cyc = cyc + 1;
        if (a_en && !a_we) begin
            e.data = (int'(a_addr) >= dp) ? 32'h0 : ((d == 1) ? m[d][a_addr] : nw[a_addr]);
            q[d*2].push_back(e);
        end
        if (b_en && !b_we) begin
            e.data = (int'(b_addr) >= dp) ? 32'h0 : ((d == 1) ? m[d][b_addr] : nw[b_addr]);
            q[d*2+1].push_back(e);
        end
        exp_coll[d] = wa && wb && (a_addr == b_addr) && ((a_be & b_be) != 0);
        m[d] = nw;
    endtask

    task automatic step();
        bit rdy;
        for (int d = 0; d < 2; d++) begin
            exp_coll[d] = 0;
            if (cyc >= dep(d) + 1) model_step(d);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            rdy = (cyc >= dep(d) + 1);
            chk($sformatf("ready%0d", d), 32'(rdy_w[d]), 32'(rdy));
            chk($sformatf("busy%0d", d), 32'(busy_w[d]), 32'(!rdy));
            chk($sformatf("collision%0d", d), 32'(coll_w[d]), 32'(exp_coll[d]));
        end
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        for (int p = 0; p < 4; p++) begin
            q[p].delete();
            last[p] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d), 32'(rdy_w[d]), 0);
            chk($sformatf("rst_busy%0d", d), 32'(busy_w[d]), 1);
            chk($sformatf("rst_collision%0d", d), 32'(coll_w[d]), 0);
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rst_rvalid_p%0d", p), 32'(rv_w[p]), 0);
            chk($sformatf("rst_dout_p%0d", p), dout_w[p], 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) m[d][w] = 0;
        end
    endtask

    task automatic randomize_inputs();
        a_en = ($urandom % 4) != 0;  a_we = 1'($urandom);  a_be = 4'($urandom);
        a_addr = 4'($urandom);  a_din = $urandom;
        b_en = ($urandom % 4) != 0;  b_we = 1'($urandom);  b_be = 4'($urandom);
        b_addr = 4'($urandom);  b_din = $urandom;
        if ($urandom % 3 == 0) b_addr = a_addr;
    endtask

    task automatic wait_clear(input bit noisy);
        int bc0, bc1;
        bc0 = 0; bc1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (noisy) randomize_inputs();
            step();
            if (busy0) bc0++;
            if (busy1) bc1++;
            if (!busy0 && !busy1) break;
        end
        chk("busy_cycles0", bc0, 16);
        chk("busy_cycles1", bc1, 12);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            set_a(0, 0, 4'(i), 0);
            set_b(0, 0, 4'(15 - i), 0);
            step();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                if (rv_w[p]) begin
                    if (q[p].size() == 0) begin
                        chk($sformatf("rvalid_unexpected_p%0d", p), 32'(rv_w[p]), 0);
                    end else begin
                        mon_e = q[p].pop_front();
                        chk($sformatf("rdata_p%0d", p), dout_w[p], mon_e.data);
                        chk($sformatf("rlatency_p%0d", p), cyc, mon_e.cyc);
                        last[p] = mon_e.data;
                    end
                end else begin
                    chk($sformatf("dout_hold_p%0d", p), dout_w[p], last[p]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        cyc = 0;
        do_reset();
        wait_clear(0);
        read_all();

        set_a(1, 4'hF, 4'd5, 32'hAABBCCDD);  step();
        set_a(1, 4'b0101, 4'd5, 32'h11223344);  step();
        set_b(0, 0, 4'd5, 0);  step();
        step();

        set_a(1, 4'b0011, 4'd7, 32'h11111111);  set_b(1, 4'b0110, 4'd7, 32'h22222222);  step();
        set_a(0, 0, 4'd7, 0);  step();
        set_a(1, 4'b0011, 4'd7, 32'h11111111);  set_b(1, 4'b1100, 4'd7, 32'h22222222);  step();
        set_b(0, 0, 4'd7, 0);  step();

        set_a(1, 4'hF, 4'd3, 32'hDEADBEEF);  step();
        set_a(1, 4'hF, 4'd3, 32'hCAFEF00D);  set_b(0, 0, 4'd3, 0);  step();
        set_b(0, 0, 4'd3, 0);  step();

        set_a(1, 4'hF, 4'd13, 32'hFFFFFFFF);  step();
        set_a(0, 0, 4'd13, 0);  step();
        set_a(1, 4'h0, 4'd2, 32'h12345678);  step();
        read_all();

        repeat (400) begin
            randomize_inputs();
            step();
        end
        read_all();

        do_reset();
        repeat (9) step();
        do_reset();
        wait_clear(1);
        read_all();

        repeat (3) step();
        for (int p = 0; p < 4; p++) chk($sformatf("pending_reads_p%0d", p), q[p].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
